retry_rrsm_responder: RTL and testbench

Remote-retry responder for the link-layer retry block. It answers a RETRY.REQ received from the link partner and raises a RETRY.ACK request towards the control-flit packer. It then rewinds the LLRB read pointer to the requested sequence number and replays the buffered flits. It sits between the unpacker, which decodes RETRY.REQ, and the controller/packer and LLRB read port on the transmit side.

---
 rtl/retry_pkg.sv | 39 +++
 rtl/retry_rrsm_responder.sv | 163 ++++++++++++++++
 tb/tb_retry_rrsm_responder.sv | 306 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/retry_pkg.sv
// Shared types and helpers for the remote-retry responder.
// Holds the RRSM state encoding and LLRB pointer arithmetic.
package retry_pkg;

    localparam int RETRY_PTR_W = 8;
    localparam int RETRY_NUM_W = 5;

    typedef enum logic [1:0] {
        RRSM_NORMAL = 2'd0,
        RRSM_LLRACK = 2'd1,
        RRSM_REPLAY = 2'd2
    } rrsm_state_e;

    function automatic logic [RETRY_PTR_W-1:0] wrap_inc(
        input logic [RETRY_PTR_W-1:0] ptr,
        input logic [RETRY_PTR_W-1:0] wrap
    );
        if (ptr == wrap)
            return '0;
        return ptr + RETRY_PTR_W'(1);
    endfunction

    function automatic logic [RETRY_PTR_W:0] replay_count(
        input logic [RETRY_PTR_W-1:0] wrt,
        input logic [RETRY_PTR_W-1:0] req,
        input logic [RETRY_PTR_W-1:0] wrap
    );
        logic [RETRY_PTR_W:0] w_w;
        logic [RETRY_PTR_W:0] w_r;
        logic [RETRY_PTR_W:0] w_k;
        w_w = {1'b0, wrt};
        w_r = {1'b0, req};
        w_k = {1'b0, wrap};
        if (wrt >= req)
            return w_w - w_r;
        return w_w + w_k + (RETRY_PTR_W+1)'(1) - w_r;
    endfunction

endpackage

// File: rtl/retry_rrsm_responder.sv
// Remote-retry responder: answers RETRY.REQ with a RETRY.ACK
// request, then rewinds the LLRB read pointer and replays flits.
module retry_rrsm_responder
    import retry_pkg::*;
#(
    parameter int PTR_W = RETRY_PTR_W,
    parameter int NUM_W = RETRY_NUM_W
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_pl_lnk_up,
    input  logic [PTR_W-1:0] i_register_file_llr_wrap_value,
    input  logic [PTR_W-1:0] i_wrt_ptr,
    input  logic             unpacker_req_seq_flag,
    input  logic [PTR_W-1:0] unpacker_rdptr_eseq_num,
    input  logic [NUM_W-1:0] unpacker_retryreq_num,
    input  logic             controller_ack_sent_flag,
    input  logic             i_replay_ready,
    output logic             retry_send_ack_seq,
    output logic [NUM_W-1:0] retry_ack_num_retry,
    output logic [PTR_W-1:0] retry_ack_wrt_ptr,
    output logic             retry_ack_empty_bit,
    output logic             retry_rd_en,
    output logic [PTR_W-1:0] retry_rd_ptr,
    output logic             retry_replay_active,
    output logic             retry_replay_done,
    output logic             retry_req_err,
    output logic [1:0]       RRSM
);

    rrsm_state_e      r_state;
    logic             r_send_ack;
    logic [NUM_W-1:0] r_num_retry;
    logic [PTR_W-1:0] r_ack_wrt_ptr;
    logic             r_empty;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_cnt;
    logic             r_done;
    logic             r_err;

    rrsm_state_e      w_state;
    logic             w_send_ack;
    logic [NUM_W-1:0] w_num_retry;
    logic [PTR_W-1:0] w_ack_wrt_ptr;
    logic             w_empty;
    logic [PTR_W-1:0] w_rd_ptr;
    logic [PTR_W:0]   w_cnt;
    logic [PTR_W:0]   w_new_cnt;
    logic             w_done;
    logic             w_err;
    logic             w_req_vld;
    logic             w_req_bad;
    logic             w_accept;
    logic             w_cnt_zero;
    logic             w_rd_en;

    // Request qualification and the zero-latency replay read strobe
    always_comb begin
        w_req_vld  = unpacker_req_seq_flag & i_pl_lnk_up;
        w_req_bad  = unpacker_rdptr_eseq_num > i_register_file_llr_wrap_value;
        w_accept   = w_req_vld & ~w_req_bad;
        w_cnt_zero = (r_cnt == '0);
        w_new_cnt  = replay_count(i_wrt_ptr, unpacker_rdptr_eseq_num,
                                  i_register_file_llr_wrap_value);
        w_rd_en    = (r_state == RRSM_REPLAY) & i_replay_ready & ~w_cnt_zero
                   & ~w_accept & i_pl_lnk_up;
    end

    // Next state; a new request always wins over ack/last-read events
    always_comb begin
        w_state       = r_state;
        w_send_ack    = r_send_ack;
        w_num_retry   = r_num_retry;
        w_ack_wrt_ptr = r_ack_wrt_ptr;
        w_empty       = r_empty;
        w_rd_ptr      = r_rd_ptr;
        w_cnt         = r_cnt;
        w_done        = 1'b0;
        w_err         = 1'b0;
        if (!i_pl_lnk_up) begin
            w_state       = RRSM_NORMAL;
            w_send_ack    = 1'b0;
            w_num_retry   = '0;
            w_ack_wrt_ptr = '0;
            w_empty       = 1'b0;
            w_rd_ptr      = '0;
            w_cnt         = '0;
        end else if (w_accept) begin
            w_state       = RRSM_LLRACK;
            w_send_ack    = 1'b1;
            w_num_retry   = unpacker_retryreq_num;
            w_ack_wrt_ptr = i_wrt_ptr;
            w_rd_ptr      = unpacker_rdptr_eseq_num;
            w_cnt         = w_new_cnt;
            w_empty       = (w_new_cnt == '0);
        end else begin
            w_err = w_req_vld;
            case (r_state)
                RRSM_NORMAL: w_state = RRSM_NORMAL;
                RRSM_LLRACK: begin
                    if (controller_ack_sent_flag) begin
                        w_send_ack = 1'b0;
                        if (w_cnt_zero) begin
                            w_state = RRSM_NORMAL;
                            w_done  = 1'b1;
                        end else begin
                            w_state = RRSM_REPLAY;
                        end
                    end
                end
                RRSM_REPLAY: begin
                    if (w_rd_en) begin
                        w_rd_ptr = wrap_inc(r_rd_ptr,
                                            i_register_file_llr_wrap_value);
                        w_cnt    = r_cnt - (PTR_W+1)'(1);
                        if (r_cnt == (PTR_W+1)'(1)) begin
                            w_state = RRSM_NORMAL;
                            w_done  = 1'b1;
                        end
                    end
                end
                default: w_state = RRSM_NORMAL;
            endcase
        end
    end

    // State and response registers
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state       <= RRSM_NORMAL;
            r_send_ack    <= 1'b0;
            r_num_retry   <= '0;
            r_ack_wrt_ptr <= '0;
            r_empty       <= 1'b0;
            r_rd_ptr      <= '0;
            r_cnt         <= '0;
            r_done        <= 1'b0;
            r_err         <= 1'b0;
        end else begin
            r_state       <= w_state;
            r_send_ack    <= w_send_ack;
            r_num_retry   <= w_num_retry;
            r_ack_wrt_ptr <= w_ack_wrt_ptr;
            r_empty       <= w_empty;
            r_rd_ptr      <= w_rd_ptr;
            r_cnt         <= w_cnt;
            r_done        <= w_done;
            r_err         <= w_err;
        end
    end

    assign retry_send_ack_seq  = r_send_ack;
    assign retry_ack_num_retry = r_num_retry;
    assign retry_ack_wrt_ptr   = r_ack_wrt_ptr;
    assign retry_ack_empty_bit = r_empty;
    assign retry_rd_en         = w_rd_en;
    assign retry_rd_ptr        = r_rd_ptr;
    assign retry_replay_active = (r_state == RRSM_REPLAY);
    assign retry_replay_done   = r_done;
    assign retry_req_err       = r_err;
    assign RRSM                = r_state;

endmodule

// File: tb/tb_retry_rrsm_responder.sv
// Bench for retry_rrsm_responder: vector table of requests plus
// hand sequences for preemption, link-down and async reset.
module tb_retry_rrsm_responder;

    typedef struct {
        logic [7:0] wrap;
        logic [7:0] wrt;
        logic [7:0] req;
        logic [4:0] num;
        logic       err;
        logic       empty;
        int         cnt;
        logic       stall;
    } vec_t;

    logic       clk;
    logic       rst_n;
    logic       lnk;
    logic [7:0] wrap;
    logic [7:0] wrt;
    logic       seq_flag;
    logic [7:0] eseq;
    logic [4:0] rnum;
    logic       ack_sent;
    logic       ready;
    logic       send_ack;
    logic [4:0] ack_num;
    logic [7:0] ack_wrt;
    logic       empty;
    logic       rd_en;
    logic [7:0] rd_ptr;
    logic       active;
    logic       done;
    logic       err;
    logic [1:0] rrsm;

    int         checks;
    int         errors;
    int         reads;
    logic [7:0] exp_q[$];
    vec_t       vt[6];
    vec_t       hv;

    retry_rrsm_responder dut (
        .i_clk                          (clk),
        .i_rst_n                        (rst_n),
        .i_pl_lnk_up                    (lnk),
        .i_register_file_llr_wrap_value (wrap),
        .i_wrt_ptr                      (wrt),
        .unpacker_req_seq_flag          (seq_flag),
        .unpacker_rdptr_eseq_num        (eseq),
        .unpacker_retryreq_num          (rnum),
        .controller_ack_sent_flag       (ack_sent),
        .i_replay_ready                 (ready),
        .retry_send_ack_seq             (send_ack),
        .retry_ack_num_retry            (ack_num),
        .retry_ack_wrt_ptr              (ack_wrt),
        .retry_ack_empty_bit            (empty),
        .retry_rd_en                    (rd_en),
        .retry_rd_ptr                   (rd_ptr),
        .retry_replay_active            (active),
        .retry_replay_done              (done),
        .retry_req_err                  (err),
        .RRSM                           (rrsm)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: every read strobe must match the next expected pointer
    always @(negedge clk) begin
        logic [7:0] e;
        if (rst_n && rd_en) begin
            reads++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL rd_unexpected got ptr %0d want no read", rd_ptr);
            end else begin
                e = exp_q.pop_front();
                if (rd_ptr !== e) begin
                    errors++;
                    $display("FAIL rd_ptr got %0d want %0d", rd_ptr, e);
                end
            end
        end
    end

    task automatic push_exp(input logic [7:0] w, input logic [7:0] s,
                            input int n);
        logic [7:0] p;
        p = s;
        exp_q.delete();
        reads = 0;
        for (int k = 0; k < n; k++) begin
            exp_q.push_back(p);
            p = (p == w) ? 8'd0 : p + 8'd1;
        end
    endtask

    task automatic send_req(input vec_t v);
        wrap = v.wrap;
        wrt = v.wrt;
        eseq = v.req;
        rnum = v.num;
        seq_flag = 1'b1;
        if (!v.err)
            push_exp(v.wrap, v.req, v.cnt);
        tick();
        seq_flag = 1'b0;
        @(negedge clk);
    endtask

    task automatic run_replay(input int n, input logic stall);
        bit got;
        ack_sent = 1'b1;
        ready = 1'b1;
        tick();
        ack_sent = 1'b0;
        got = 0;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            if (done) begin
                got = 1;
                break;
            end
            tick();
            ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
        end
        chk("done_seen", int'(got), 1);
        chk("end_state", int'(rrsm), 0);
        chk("read_count", reads, n);
        chk("reads_left", exp_q.size(), 0);
        chk("ack_dropped", int'(send_ack), 0);
        chk("active_end", int'(active), 0);
        tick();
        @(negedge clk);
        chk("done_pulse", int'(done), 0);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reads = 0;
        rst_n = 1'b0;
        lnk = 1'b0;
        wrap = 8'd255;
        wrt = 8'd0;
        seq_flag = 1'b0;
        eseq = 8'd0;
        rnum = 5'd0;
        ack_sent = 1'b0;
        ready = 1'b0;

        vt[0] = '{8'd255, 8'd20, 8'd10, 5'd3, 1'b0, 1'b0, 10, 1'b0};
        vt[1] = '{8'd15, 8'd2, 8'd13, 5'd7, 1'b0, 1'b0, 5, 1'b1};
        vt[2] = '{8'd255, 8'd7, 8'd7, 5'd1, 1'b0, 1'b1, 0, 1'b0};
        vt[3] = '{8'd15, 8'd9, 8'd20, 5'd2, 1'b1, 1'b0, 0, 1'b0};
        vt[4] = '{8'd255, 8'd5, 8'd200, 5'd31, 1'b0, 1'b0, 61, 1'b0};
        vt[5] = '{8'd255, 8'd0, 8'd255, 5'd9, 1'b0, 1'b0, 1, 1'b1};

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_state", int'(rrsm), 0);
        chk("rst_send_ack", int'(send_ack), 0);
        chk("rst_rd_ptr", int'(rd_ptr), 0);
        chk("rst_ack_wrt", int'(ack_wrt), 0);
        chk("rst_ack_num", int'(ack_num), 0);
        chk("rst_empty", int'(empty), 0);
        chk("rst_done_err", int'({done, err}), 0);
        rst_n = 1'b1;
        lnk = 1'b1;
        tick();

        for (int i = 0; i < 6; i++) begin
            send_req(vt[i]);
            if (vt[i].err) begin
                chk("err_pulse", int'(err), 1);
                chk("err_state", int'(rrsm), 0);
                chk("err_send_ack", int'(send_ack), 0);
                tick();
                @(negedge clk);
                chk("err_once", int'(err), 0);
            end else begin
                chk("acc_state", int'(rrsm), 1);
                chk("acc_send_ack", int'(send_ack), 1);
                chk("acc_ack_wrt", int'(ack_wrt), int'(vt[i].wrt));
                chk("acc_ack_num", int'(ack_num), int'(vt[i].num));
                chk("acc_empty", int'(empty), int'(vt[i].empty));
                chk("acc_rd_ptr", int'(rd_ptr), int'(vt[i].req));
                chk("acc_err", int'(err), 0);
                run_replay(vt[i].cnt, vt[i].stall);
            end
        end

        // second request preempts a running replay
        hv = '{8'd255, 8'd20, 8'd10, 5'd3, 1'b0, 1'b0, 10, 1'b0};
        send_req(hv);
        ack_sent = 1'b1;
        ready = 1'b1;
        tick();
        ack_sent = 1'b0;
        repeat (3) tick();
        wrt = 8'd9;
        eseq = 8'd4;
        rnum = 5'd5;
        push_exp(8'd255, 8'd4, 5);
        seq_flag = 1'b1;
        @(negedge clk);
        chk("pre_rd_en", int'(rd_en), 0);
        tick();
        seq_flag = 1'b0;
        @(negedge clk);
        chk("pre_state", int'(rrsm), 1);
        chk("pre_send_ack", int'(send_ack), 1);
        chk("pre_rd_ptr", int'(rd_ptr), 4);
        chk("pre_ack_wrt", int'(ack_wrt), 9);
        chk("pre_done", int'(done), 0);
        repeat (2) begin
            tick();
            @(negedge clk);
            chk("hold_state", int'(rrsm), 1);
            chk("hold_rd_en", int'(rd_en), 0);
            chk("hold_send_ack", int'(send_ack), 1);
            chk("hold_done", int'(done), 0);
        end
        run_replay(5, 1'b0);

        // link drop during replay with ready toggling
        hv = '{8'd255, 8'd50, 8'd10, 5'd4, 1'b0, 1'b0, 40, 1'b0};
        send_req(hv);
        ack_sent = 1'b1;
        ready = 1'b1;
        tick();
        ack_sent = 1'b0;
        repeat (4) begin
            tick();
            ready = ~ready;
        end
        lnk = 1'b0;
        exp_q.delete();
        tick();
        @(negedge clk);
        chk("ld_state", int'(rrsm), 0);
        chk("ld_send_ack", int'(send_ack), 0);
        chk("ld_rd_en", int'(rd_en), 0);
        chk("ld_rd_ptr", int'(rd_ptr), 0);
        chk("ld_ack_wrt", int'(ack_wrt), 0);
        chk("ld_ack_num", int'(ack_num), 0);
        chk("ld_active", int'(active), 0);
        chk("ld_done", int'(done), 0);
        eseq = 8'd3;
        seq_flag = 1'b1;
        tick();
        seq_flag = 1'b0;
        @(negedge clk);
        chk("ld_req_state", int'(rrsm), 0);
        chk("ld_req_ack", int'(send_ack), 0);
        chk("ld_req_err", int'(err), 0);
        lnk = 1'b1;
        tick();

        // async reset while waiting for the ACK to go out
        hv = '{8'd255, 8'd30, 8'd5, 5'd2, 1'b0, 1'b0, 25, 1'b0};
        send_req(hv);
        chk("ar_pre_state", int'(rrsm), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_state", int'(rrsm), 0);
        chk("ar_send_ack", int'(send_ack), 0);
        chk("ar_rd_ptr", int'(rd_ptr), 0);
        chk("ar_ack_wrt", int'(ack_wrt), 0);
        chk("ar_ack_num", int'(ack_num), 0);
        exp_q.delete();
        tick();
        rst_n = 1'b1;
        tick();
        @(negedge clk);
        chk("ar_done", int'(done), 0);
        chk("ar_state_after", int'(rrsm), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
